// File: rtl/wash_pkg.sv
// Shared state encodings, phase index type and phase-length lookup for the wash cycle controller.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_FILL,
    PH_WASH,
    PH_RINSE,
    PH_SPIN
  } phase_t;

  localparam int TL_W = 8;

  function automatic phase_t phase_of(state_t st);
    phase_t ph;
    case (st)
      ST_WASH:  ph = PH_WASH;
      ST_RINSE: ph = PH_RINSE;
      ST_SPIN:  ph = PH_SPIN;
      default:  ph = PH_FILL;
    endcase
    return ph;
  endfunction

  // IDLE and the unused encodings have no phase, so they report a length of zero.
  function automatic logic [TL_W-1:0] phase_min(state_t st, int fill_min, int wash_min,
                                                int rinse_min, int spin_min);
    logic [TL_W-1:0] len;
    len = '0;
    if (st inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN}) begin
      case (phase_of(st))
        PH_FILL:  len = TL_W'(fill_min);
        PH_WASH:  len = TL_W'(wash_min);
        PH_RINSE: len = TL_W'(rinse_min);
        PH_SPIN:  len = TL_W'(spin_min);
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Shared phase timer: minute prescaler plus saturating minute counter; exposes min_cnt
// only when WASH_TIMELEFT_EN is defined.
module wash_phase_timer #(
  parameter int MIN_CYCLES = 60,
  parameter int MIN_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [MIN_W-1:0] len_min,
  output logic             expired
`ifdef WASH_TIMELEFT_EN
  ,
  output logic [MIN_W-1:0] min_cnt
`endif
);

  localparam int PW = $clog2(MIN_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(MIN_CYCLES - 1);

  logic [PW-1:0]    presc;
  logic [MIN_W-1:0] minute;
  logic             wrap;
  logic             last_min;

  assign wrap     = (presc == PRE_LAST);
  assign last_min = (minute == (len_min - MIN_W'(1)));
  // A held timer never expires, so a pause coinciding with the final tick wins.
  assign expired  = wrap && last_min && !hold;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc  <= '0;
      minute <= '0;
    end else if (!hold) begin
      if (wrap) begin
        presc <= '0;
        if (!last_min) minute <= minute + MIN_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef WASH_TIMELEFT_EN
  assign min_cnt = minute;
`endif

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle controller: IDLE->FILL->WASH->RINSE(->WASH->RINSE)*->SPIN->IDLE.
// Optional time_left_min output is enabled by defining WASH_TIMELEFT_EN.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int MIN_CYCLES = 60,
  parameter int FILL_MIN   = 2,
  parameter int WASH_MIN   = 5,
  parameter int RINSE_MIN  = 2,
  parameter int SPIN_MIN   = 1,
  parameter int MAX_ROUNDS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin,
  input  logic       double_wash,
  input  logic       pause,
  output logic [2:0] current_state,
  output logic       busy,
  output logic       wash_done
`ifdef WASH_TIMELEFT_EN
  ,
  output logic [7:0] time_left_min
`endif
);

  localparam int MAX_FW  = (FILL_MIN > WASH_MIN) ? FILL_MIN : WASH_MIN;
  localparam int MAX_RS  = (RINSE_MIN > SPIN_MIN) ? RINSE_MIN : SPIN_MIN;
  localparam int MAX_MIN = (MAX_FW > MAX_RS) ? MAX_FW : MAX_RS;
  localparam int MIN_W   = $clog2(MAX_MIN + 1);
  localparam int RW      = $clog2(MAX_ROUNDS + 1);

  state_t           state;
  state_t           next_state;
  logic             busy_next;
  logic             done_next;
  logic             expired;
  logic             hold;
  logic             clr;
  logic [TL_W-1:0]  cur_len;
  logic [MIN_W-1:0] len_min;
  logic [RW-1:0]    rounds_lat;
  logic [RW-1:0]    round_cnt;
  logic [RW:0]      round_inc;

  assign cur_len   = phase_min(state, FILL_MIN, WASH_MIN, RINSE_MIN, SPIN_MIN);
  assign len_min   = MIN_W'(cur_len);
  assign hold      = (state == ST_SPIN) && pause;
  // Timer stays cleared in IDLE and restarts on every state change.
  assign clr       = (state == ST_IDLE) || (next_state != state);
  assign round_inc = {1'b0, round_cnt} + (RW + 1)'(1);

`ifdef WASH_TIMELEFT_EN
  logic [MIN_W-1:0] min_cnt;
`endif

  wash_phase_timer #(
    .MIN_CYCLES(MIN_CYCLES),
    .MIN_W     (MIN_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .hold   (hold),
    .len_min(len_min),
    .expired(expired)
`ifdef WASH_TIMELEFT_EN
    ,
    .min_cnt(min_cnt)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE:  if (coin) next_state = ST_FILL;
      ST_FILL:  if (expired) next_state = ST_WASH;
      ST_WASH:  if (expired) next_state = ST_RINSE;
      ST_RINSE: if (expired) next_state = (round_inc < {1'b0, rounds_lat}) ? ST_WASH : ST_SPIN;
      ST_SPIN: begin
        if (expired) begin
          next_state = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
    busy_next = (next_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      wash_done <= 1'b0;
    end else begin
      busy      <= busy_next;
      wash_done <= done_next;
    end
  end

  // The round request is captured only with an accepted coin; later changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_lat <= '0;
      round_cnt  <= '0;
    end else if ((state == ST_IDLE) && coin) begin
      rounds_lat <= double_wash ? RW'(MAX_ROUNDS) : RW'(1);
      round_cnt  <= '0;
    end else if ((state == ST_RINSE) && expired) begin
      round_cnt  <= round_inc[RW-1:0];
    end
  end

  assign current_state = state;

`ifdef WASH_TIMELEFT_EN
  always_ff @(posedge clk) begin
    if (rst)      time_left_min <= '0;
    else if (clr) time_left_min <= phase_min(next_state, FILL_MIN, WASH_MIN, RINSE_MIN, SPIN_MIN);
    else          time_left_min <= cur_len - TL_W'(min_cnt);
  end
`endif

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl at MIN_CYCLES=4; also checks time_left_min when
// WASH_TIMELEFT_EN is defined.
`timescale 1ns/1ps
module tb_wash_cycle_ctrl;
  import wash_pkg::*;

  localparam int MC        = 4;
  localparam int FILL_MIN  = 2;
  localparam int WASH_MIN  = 5;
  localparam int RINSE_MIN = 2;
  localparam int SPIN_MIN  = 1;
`ifdef WASH_TIMELEFT_EN
  localparam bit TL_EN = 1'b1;
`else
  localparam bit TL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       coin;
  logic       double_wash;
  logic       pause;
  logic [2:0] current_state;
  logic       busy;
  logic       wash_done;
  logic [7:0] tl_obs;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cur_cycle = 0;
  logic [15:0] sb_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  wash_cycle_ctrl #(
    .MIN_CYCLES(MC),
    .FILL_MIN  (FILL_MIN),
    .WASH_MIN  (WASH_MIN),
    .RINSE_MIN (RINSE_MIN),
    .SPIN_MIN  (SPIN_MIN),
    .MAX_ROUNDS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .double_wash  (double_wash),
    .pause        (pause),
    .current_state(current_state),
    .busy         (busy),
    .wash_done    (wash_done)
`ifdef WASH_TIMELEFT_EN
    ,
    .time_left_min(tl_obs)
`endif
  );

`ifndef WASH_TIMELEFT_EN
  assign tl_obs = 8'd0;
`endif

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(logic [2:0] st, logic b, logic d, logic [7:0] tl);
    return {3'b000, st, b, d, tl};
  endfunction

  // Minutes remaining, one cycle behind the minute counter, never below one inside a phase.
  function automatic logic [7:0] exp_tl(int len, int i);
    int m;
    m = (i == 0) ? 0 : (i - 1) / MC;
    if (m > len - 1) m = len - 1;
    return TL_EN ? 8'(len - m) : 8'd0;
  endfunction

  task automatic push_phase(input state_t st, input int n, input int len);
    for (int i = 0; i < n; i++) pend_q.push_back(pack(st, 1'b1, 1'b0, exp_tl(len, i)));
  endtask

  task automatic push_idle(input int n, input logic first_done);
    for (int i = 0; i < n; i++) pend_q.push_back(pack(ST_IDLE, 1'b0, first_done && (i == 0), 8'd0));
  endtask

  task automatic build_cycle(input int rounds, input int extra_spin);
    push_idle(1, 1'b0);
    push_phase(ST_FILL, FILL_MIN * MC, FILL_MIN);
    for (int r = 0; r < rounds; r++) begin
      push_phase(ST_WASH, WASH_MIN * MC, WASH_MIN);
      push_phase(ST_RINSE, RINSE_MIN * MC, RINSE_MIN);
    end
    push_phase(ST_SPIN, SPIN_MIN * MC + extra_spin, SPIN_MIN);
    push_idle(4, 1'b1);
  endtask

  // Entry c of the scoreboard is the DUT value seen by edge c; inputs for edge c are driven here.
  task automatic apply_stimulus(input int dw_until, input int p_lo, input int p_hi, input int rst_at,
                                input int c1, input int c2, input int c3);
    int n;
    n = pend_q.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        sb_q = pend_q;
        pend_q.delete();
      end
      cur_cycle   = c;
      coin        = (c == 0) || (c == c1) || (c == c2) || (c == c3);
      double_wash = (c <= dw_until) || (coin && (c != 0));
      pause       = (c >= p_lo) && (c <= p_hi);
      rst         = (c == rst_at);
    end
    @(posedge clk);
    #1;
    {coin, double_wash, pause, rst} = 4'b0000;
    for (int k = 0; k < 8 && sb_q.size() > 0; k++) @(negedge clk);
    check_output("sb_drain", 16'(sb_q.size()), 16'd0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      check_output($sformatf("trace_c%0d", cur_cycle),
                   pack(current_state, busy, wash_done, tl_obs), mon_exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    coin        = 1'b1;
    double_wash = 1'b1;
    pause       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_state", 16'(current_state), 16'(ST_IDLE));
    check_output("rst_busy", 16'(busy), 16'd0);
    check_output("rst_done", 16'(wash_done), 16'd0);
    check_output("rst_tl", 16'(tl_obs), 16'd0);
    rst         = 1'b0;
    coin        = 1'b0;
    double_wash = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] single cycle");
    build_cycle(1, 0);
    apply_stimulus(-1, -1, -1, -1, -1, -1, -1);

    $display("[TB] double wash, request dropped at cycle 10");
    build_cycle(2, 0);
    apply_stimulus(10, -1, -1, -1, -1, -1, -1);

    $display("[TB] pause for 3 cycles inside SPIN");
    build_cycle(1, 3);
    apply_stimulus(-1, 38, 40, -1, -1, -1, -1);

    $display("[TB] pause during WASH");
    build_cycle(1, 0);
    apply_stimulus(-1, 12, 14, -1, -1, -1, -1);

    $display("[TB] reset mid-WASH");
    push_idle(1, 1'b0);
    push_phase(ST_FILL, FILL_MIN * MC, FILL_MIN);
    push_phase(ST_WASH, 7, WASH_MIN);
    push_idle(4, 1'b0);
    apply_stimulus(-1, -1, -1, 15, -1, -1, -1);

    $display("[TB] restart after reset");
    build_cycle(1, 0);
    apply_stimulus(-1, -1, -1, -1, -1, -1, -1);

    $display("[TB] coins while busy");
    build_cycle(1, 0);
    apply_stimulus(-1, -1, -1, -1, 5, 30, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
